// File: rtl/uart.sv
// Fixed-rate 8N1 UART transceiver with independent transmitter and receiver.
// Define UART_RX_FRAME_CHECK_EN to drop received bytes whose stop bit samples low.
module uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       tx_ready,
    output logic       rx_ready
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [1:0] TxIdle  = 2'd0;
    localparam logic [1:0] TxStart = 2'd1;
    localparam logic [1:0] TxData  = 2'd2;
    localparam logic [1:0] TxStop  = 2'd3;

    localparam logic [2:0] RxIdle    = 3'd0;
    localparam logic [2:0] RxStart   = 3'd1;
    localparam logic [2:0] RxData    = 3'd2;
    localparam logic [2:0] RxStop    = 3'd3;
`ifdef UART_RX_FRAME_CHECK_EN
    localparam logic [2:0] RxStopErr = 3'd4;
`endif

    // ---------------- transmitter ----------------
    logic [1:0]      tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_ready   = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                tx_d = 1'b1;
                if (tx_req) begin
                    tx_state_d = TxStart;
                    tx_shift_d = tx_data;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                end
            end
            TxStart: begin
                if (tx_cnt_q == CntLast) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CntOne;
                end
            end
            TxData: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CntOne;
                end
            end
            TxStop: begin
                if (tx_cnt_q == CntLast) begin
                    tx_ready   = 1'b1;
                    tx_state_d = TxIdle;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CntOne;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // tx is a preset flop so reset forces the line idle without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

    // ---------------- receiver ----------------
    logic [1:0]      rx_sync_q;
    logic            rx_s;
    logic [2:0]      rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_ready_q, rx_ready_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
        end
    end

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (!rx_s) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntOne;
                end
            end
            RxData: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CntOne;
                end
            end
            RxStop: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
`ifdef UART_RX_FRAME_CHECK_EN
                    if (rx_s) begin
                        rx_data_d  = rx_shift_q;
                        rx_ready_d = 1'b1;
                    end else begin
                        rx_state_d = RxStopErr;
                    end
`else
                    rx_data_d  = rx_shift_q;
                    rx_ready_d = 1'b1;
`endif
                end else begin
                    rx_cnt_d = rx_cnt_q + CntOne;
                end
            end
`ifdef UART_RX_FRAME_CHECK_EN
            RxStopErr: begin
                if (rx_s) begin
                    rx_state_d = RxIdle;
                end
            end
`endif
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_ready = rx_ready_q;

endmodule

// File: tb/tb_uart.sv
// Randomized self-checking bench for uart at 16 clocks per bit; the expected
// serial waveform and received bytes come from the 8N1 frame rules directly.
module tb_uart;

    localparam int unsigned Cpb = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       rx_drv;
    logic       loop;
    logic       rx_line;
    logic       tx;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       rx_ready;

    int         n_checks = 0;
    int         n_errors = 0;
    int         tx_pulses = 0;
    int         rx_pulses = 0;
    logic [7:0] rx_got[$];
    logic [7:0] exp_q[$];
    logic [7:0] prev_rx_data = 8'h00;
    logic [7:0] last_good;

    assign rx_line = loop ? tx : rx_drv;

    uart #(.CLKS_PER_BIT(Cpb)) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .rx      (rx_line),
        .tx      (tx),
        .rx_data (rx_data),
        .tx_ready(tx_ready),
        .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rx_ready) begin
            rx_got.push_back(rx_data);
            rx_pulses++;
        end
        if (tx_ready) tx_pulses++;
        if (!reset && rx_data !== prev_rx_data)
            check("rx_data_changes_only_with_ready", 32'(rx_ready), 32'd1);
        prev_rx_data = rx_data;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, 32'(rx_got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_got.size(); i++)
            check(tag, 32'(rx_got[i]), 32'(exp_q[i]));
        rx_got.delete();
        exp_q.delete();
    endtask

    // Sends one byte through tx, pokes tx_req while busy, optionally in the tx_ready cycle,
    // and returns one cycle after tx_ready so the next request is back-to-back.
    task automatic send_frame(input logic [7:0] b, input bit poke_ready);
        int cyc;
        int poke_at;
        tx_data = b;
        tx_req  = 1'b1;
        if (loop) exp_q.push_back(b);
        @(negedge clk);
        tx_req  = 1'b0;
        tx_data = 8'($urandom);
        check("tx_start_latency", 32'(tx), 32'd0);
        poke_at = $urandom_range(3, 150);
        cyc = 1;
        while (!tx_ready && cyc < 400) begin
            tx_req = (cyc == poke_at);
            if (cyc == poke_at) tx_data = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        tx_req = 1'b0;
        check("tx_ready_seen", 32'(tx_ready), 32'd1);
        check("tx_frame_len", 32'(cyc), 32'(10 * Cpb));
        if (poke_ready) begin
            tx_req  = 1'b1;
            tx_data = 8'($urandom);
        end
        @(negedge clk);
        tx_req = 1'b0;
        if (poke_ready) check("tx_req_in_ready_ignored", 32'(tx), 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (Cpb) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (3 * Cpb) @(negedge clk);
    endtask

    task automatic reset_mid(input logic [7:0] b, input int delay);
        int t0;
        int r0;
        loop    = 1'b1;
        t0      = tx_pulses;
        r0      = rx_pulses;
        tx_data = b;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        repeat (delay) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_tx_async_high", 32'(tx), 32'd1);
        check("reset_tx_ready_low", 32'(tx_ready), 32'd0);
        check("reset_rx_ready_low", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12 * Cpb) @(negedge clk);
        check("reset_no_tx_ready", 32'(tx_pulses), 32'(t0));
        check("reset_no_rx_ready", 32'(rx_pulses), 32'(r0));
        check("reset_rx_data_cleared", 32'(rx_data), 32'h00);
        rx_got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [9:0] f;
        logic [7:0] r;
        reset   = 1'b1;
        tx_req  = 1'b0;
        tx_data = 8'h00;
        rx_drv  = 1'b1;
        loop    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'h00);

        // Exact waveform of an A5 frame.
        f       = {1'b1, 8'hA5, 1'b0};
        tx_data = 8'hA5;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        for (int k = 0; k < 10 * int'(Cpb); k++) begin
            check("a5_tx_bit", 32'(tx), 32'(f[k / Cpb]));
            check("a5_tx_ready", 32'(tx_ready), 32'(k == 10 * Cpb - 1));
            @(negedge clk);
        end
        check("a5_tx_idle_after", 32'(tx), 32'd1);
        repeat (4) @(negedge clk);

        // Loopback, fixed bytes then random ones.
        loop = 1'b1;
        send_frame(8'hDE, 1'b0);
        send_frame(8'hAD, 1'b1);
        send_frame(8'hBE, 1'b0);
        send_frame(8'hEF, 1'b1);
        for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'($urandom));
        repeat (2 * Cpb) @(negedge clk);
        compare_rx("loopback_rx");

        // Glitch rejection, then bit-banged frames with random preceding glitches.
        loop   = 1'b0;
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * Cpb) @(negedge clk);
        check("glitch_no_rx_ready", 32'(rx_got.size()), 32'd0);
        drive_frame(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        last_good = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            rx_drv = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            rx_drv = 1'b1;
            repeat (2 * Cpb) @(negedge clk);
            r = 8'($urandom);
            drive_frame(r, 1'b1);
            exp_q.push_back(r);
            last_good = r;
        end
        compare_rx("bitbang_rx");
        check("bitbang_last_data", 32'(rx_data), 32'(last_good));

        // Stop bit driven low.
        drive_frame(8'h55, 1'b0);
        repeat (2 * Cpb) @(negedge clk);
`ifdef UART_RX_FRAME_CHECK_EN
        check("bad_stop_data_kept", 32'(rx_data), 32'(last_good));
`else
        exp_q.push_back(8'h55);
        check("bad_stop_data", 32'(rx_data), 32'h55);
`endif
        compare_rx("bad_stop_rx");
        drive_frame(8'hC3, 1'b1);
        exp_q.push_back(8'hC3);
        compare_rx("after_bad_stop_rx");

        // Reset mid-frame, then a normal transfer.
        reset_mid(8'hFF, 4 * Cpb + 5);
        reset_mid(8'($urandom), 3);
        loop = 1'b1;
        send_frame(8'h81, 1'b0);
        repeat (2 * Cpb) @(negedge clk);
        compare_rx("post_reset_rx");
        check("post_reset_rx_data", 32'(rx_data), 32'h81);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
